axi_r_router: RTL

Read-response router for the two-master AXI interconnect. It sits on the slave side of the shared read path, behind the AR arbiter. It records, in issue order, which master won each accepted AR transfer. It then steers the slave's R-channel beats back to that master until RLAST, and stalls further AR grants when its owner queue is full.

---
 rtl/axi_r_router.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_r_router.sv
// -----------------------------------------------------------------------------
// axi_r_router
//
// Read-response router for a two-master AXI interconnect. Sits on the slave
// side of the shared read path, behind the AR arbiter. Every accepted AR
// transfer pushes its owner (M0/M1) into a small circular FIFO in issue order.
// The FIFO head selects which master receives the slave's R beats. The head is
// popped on the handshaked RLAST beat. While the FIFO is full, ar_block tells
// the arbiter to withhold further AR grants.
//
// Parameters
//   DATA_W      R data width
//   DEPTH       maximum outstanding read bursts (power of two, >= 2)
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   ar_hs, ar_sel                AR handshake on shared bus / owner of that AR
//   ar_block                     owner queue full, hold off AR grants
//   s_rvalid/rdata/rresp/rlast   R channel from the slave
//   s_rready                     ready back to the slave
//   m0_r*, m1_r*                 R channel towards master 0 / master 1
//   outstanding                  number of queued bursts (registered)
//   err_stray                    sticky: R beat accepted while queue empty
//
// Configuration
//   R_ROUTER_ERR_EN  When defined, beats that arrive with an empty queue are
//                    sunk (s_rready=1) and flagged in err_stray. When
//                    undefined, such beats are stalled and err_stray is 0.
// -----------------------------------------------------------------------------
module axi_r_router #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       ar_hs,
  input  logic                       ar_sel,
  output logic                       ar_block,

  input  logic                       s_rvalid,
  input  logic [DATA_W-1:0]          s_rdata,
  input  logic [1:0]                 s_rresp,
  input  logic                       s_rlast,
  output logic                       s_rready,

  output logic                       m0_rvalid,
  output logic [DATA_W-1:0]          m0_rdata,
  output logic [1:0]                 m0_rresp,
  output logic                       m0_rlast,
  input  logic                       m0_rready,

  output logic                       m1_rvalid,
  output logic [DATA_W-1:0]          m1_rdata,
  output logic [1:0]                 m1_rresp,
  output logic                       m1_rlast,
  input  logic                       m1_rready,

  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err_stray
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

`ifdef R_ROUTER_ERR_EN
  localparam logic EMPTY_RREADY = 1'b1;
`else
  localparam logic EMPTY_RREADY = 1'b0;
`endif

  // Owner queue storage and bookkeeping
  logic [DEPTH-1:0] owner_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic   not_empty;
  logic   full;
  logic   push;
  logic   pop;
  logic   r_hs;
  owner_e head_owner;

  assign not_empty  = (count_q != '0);
  assign full       = (count_q == FULL_CNT);
  assign head_owner = owner_e'(owner_q[rd_ptr_q]);

  // ---------------------------------------------------------------------------
  // Routing: purely combinational, zero added latency in both directions.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before any branch so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    m0_rvalid = 1'b0;
    m0_rdata  = '0;
    m0_rresp  = 2'b00;
    m0_rlast  = 1'b0;
    m1_rvalid = 1'b0;
    m1_rdata  = '0;
    m1_rresp  = 2'b00;
    m1_rlast  = 1'b0;
    s_rready  = EMPTY_RREADY;

    if (not_empty) begin
      if (head_owner == OWNER_M1) begin
        m1_rvalid = s_rvalid;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        m1_rlast  = s_rlast;
        s_rready  = m1_rready;
      end else begin
        m0_rvalid = s_rvalid;
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        m0_rlast  = s_rlast;
        s_rready  = m0_rready;
      end
    end
  end

  assign r_hs = s_rvalid & s_rready;

  // Only a handshaked last beat of a queued burst retires the head; stray
  // beats on an empty queue never touch the pointers.
  assign pop  = r_hs & s_rlast & not_empty;

  // A full queue still accepts an AR in the same cycle as a pop: the slot
  // freed by the pop is reused, so the count stays at DEPTH. A push while
  // full with no pop is a protocol violation and is dropped.
  assign push = ar_hs & (~full | pop);

  // ---------------------------------------------------------------------------
  // Queue next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the owner storage is deliberately not reset; an entry is only ever
  // read while count_q says it holds a valid push, so its reset value is
  // irrelevant and leaving it out keeps the storage a plain register file.
  always_ff @(posedge clk) begin
    if (push) begin
      owner_q[wr_ptr_q] <= ar_sel;
    end
  end

  assign ar_block    = full;
  assign outstanding = count_q;

  // ---------------------------------------------------------------------------
  // Stray-beat detection
  // ---------------------------------------------------------------------------
`ifdef R_ROUTER_ERR_EN
  logic err_stray_q, err_stray_d;

  assign err_stray_d = err_stray_q | (r_hs & ~not_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_stray_q <= 1'b0;
    end else begin
      err_stray_q <= err_stray_d;
    end
  end

  assign err_stray = err_stray_q;
`else
  assign err_stray = 1'b0;
`endif

endmodule
